// File: rtl/heap_feeder_pkg.sv
//------------------------------------------------------------------------------
// heap_feeder_pkg
// Shared types and helpers for the heap feeder and the heap it drives.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

`ifndef HEAP_KEY
`define HEAP_KEY(d, kw) d[(kw)-1:0]
`endif

package heap_feeder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_FILL  = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

  function automatic int cap_of(input int nlevels);
    return (1 << nlevels) - 1;
  endfunction

  function automatic int cnt_width(input int nlevels);
    return nlevels + 8;
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

`default_nettype wire

// File: rtl/heap_feeder_fifo.sv
//------------------------------------------------------------------------------
// heap_feeder_fifo
// Synchronous FIFO with full/empty; a push into a full FIFO succeeds if a pop
// happens in the same cycle.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module heap_feeder_fifo
  import heap_feeder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 7
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = ptr_width(DEPTH);
  localparam int NW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [NW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == NW'(DEPTH));
  assign empty   = (count_q == '0);
  assign dout    = mem_q[rd_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (do_push) begin
      mem_d[wr_q] = din;
      wr_d        = (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
    end
    if (do_pop) begin
      rd_d = (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_q   <= '{default: '0};
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/heap_feeder.sv
//------------------------------------------------------------------------------
// heap_feeder
// Feeds one frame into the heap sorter, captures its sorted burst and replays
// it downstream. Optional drop counter: HEAP_FEEDER_DROPCNT_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module heap_feeder
  import heap_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int KEY_WIDTH  = 4,
  parameter int NLEVELS    = 3
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic [DATA_WIDTH-1:0] heap_din,
  output logic                  heap_en,
  output logic                  heap_init,
  output logic                  heap_flush,
  input  logic [DATA_WIDTH-1:0] heap_dout,
  input  logic                  heap_valid,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done,
`ifdef HEAP_FEEDER_DROPCNT_EN
  output logic [15:0]           drop_cnt,
`endif
  output logic                  err
);

  localparam int CAP = cap_of(NLEVELS);
  localparam int NW  = cnt_width(NLEVELS);
  localparam int CW  = $clog2(CAP + 1);
  localparam logic [NW-1:0] N_MAX = {NW{1'b1}};

  // An out-of-range key width leaves this marker scope in the hierarchy.
  if (KEY_WIDTH < 1 || KEY_WIDTH > DATA_WIDTH) begin : g_bad_key_width
  end

  state_e                state_q, state_d;
  logic [NW-1:0]         n_q, n_d;
  logic [CW-1:0]         cap_cnt_q, cap_cnt_d;
  logic [CW-1:0]         pop_cnt_q, pop_cnt_d;
  logic                  err_q, err_d;
  logic                  done_q, done_d;
  logic                  heap_en_q, heap_en_d;
  logic [DATA_WIDTH-1:0] heap_din_q, heap_din_d;
  logic [CW-1:0]         exp_cnt;
  logic                  accept, err_set, err_clr;
  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic                  last_pop;

  assign exp_cnt  = (n_q > NW'(CAP)) ? CW'(CAP) : n_q[CW-1:0];
  assign s_ready  = (state_q == ST_FILL);
  assign accept   = s_valid && s_ready;
  assign m_valid  = !fifo_empty;
  assign fifo_pop = m_valid && m_ready;
  assign last_pop = (CW'(pop_cnt_q + 1'b1) == exp_cnt);

  assign heap_init  = (state_q == ST_INIT);
  assign heap_flush = (state_q == ST_FLUSH);
  assign heap_en    = heap_en_q;
  assign heap_din   = heap_din_q;
  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  assign err        = err_q;
  assign m_last     = m_valid && (state_q == ST_DRAIN) && last_pop;

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    cap_cnt_d  = cap_cnt_q;
    pop_cnt_d  = pop_cnt_q;
    done_d     = 1'b0;
    heap_en_d  = 1'b0;
    heap_din_d = heap_din_q;
    fifo_push  = 1'b0;
    err_set    = 1'b0;
    err_clr    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_INIT;
          n_d       = '0;
          cap_cnt_d = '0;
          pop_cnt_d = '0;
          err_clr   = 1'b1;
        end
      end
      ST_INIT: state_d = ST_FILL;
      ST_FILL: begin
        if (accept) begin
          heap_en_d  = 1'b1;
          heap_din_d = s_data;
          if (n_q != N_MAX) n_d = n_q + 1'b1;
          if (s_last) state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (fifo_pop) begin
          pop_cnt_d = pop_cnt_q + 1'b1;
          // Final pop with every expected beat already captured empties the FIFO.
          if (last_pop && cap_cnt_q == exp_cnt) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // The heap cannot be stalled: a beat is either stored now or lost.
    if (heap_valid) begin
      if (state_q == ST_DRAIN && cap_cnt_q < exp_cnt) begin
        if (!fifo_full || fifo_pop) begin
          fifo_push = 1'b1;
          cap_cnt_d = cap_cnt_q + 1'b1;
        end else begin
          err_set = 1'b1;
        end
      end else begin
        err_set = 1'b1;
      end
    end

    err_d = (err_q && !err_clr) || err_set;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      n_q        <= '0;
      cap_cnt_q  <= '0;
      pop_cnt_q  <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      heap_en_q  <= 1'b0;
      heap_din_q <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      cap_cnt_q  <= cap_cnt_d;
      pop_cnt_q  <= pop_cnt_d;
      err_q      <= err_d;
      done_q     <= done_d;
      heap_en_q  <= heap_en_d;
      heap_din_q <= heap_din_d;
    end
  end

`ifdef HEAP_FEEDER_DROPCNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (state_q == ST_FILL && state_d == ST_FLUSH) begin
      if (32'(n_d) <= 32'(CAP))
        drop_cnt_d = '0;
      else if ((32'(n_d) - 32'(CAP)) > 32'h0000_FFFF)
        drop_cnt_d = 16'hFFFF;
      else
        drop_cnt_d = 16'(32'(n_d) - 32'(CAP));
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) drop_cnt_q <= '0;
    else       drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`endif

  heap_feeder_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (CAP)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (fifo_push),
    .din   (heap_dout),
    .pop   (fifo_pop),
    .dout  (m_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

`default_nettype wire

// File: tb/tb_heap_feeder.sv
//------------------------------------------------------------------------------
// tb_heap_feeder
// Directed bench for heap_feeder; the bench plays the role of the heap.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_heap_feeder;

  logic       clk = 1'b0;
  logic       rstn, start, s_valid, s_last, heap_valid, m_ready;
  logic [7:0] s_data, heap_dout;
  logic       s_ready, heap_en, heap_init, heap_flush, m_valid, m_last;
  logic       busy, done, err;
  logic [7:0] heap_din, m_data;
`ifdef HEAP_FEEDER_DROPCNT_EN
  logic [15:0] drop_cnt;
`endif

  int errors = 0;
  int checks = 0;

  logic [7:0] items [32];
  logic [7:0] beats [8];
  logic [7:0] out_data [16];
  logic       out_last [16];
  int         out_n, done_iter, last_pop_iter;

  always #5 clk = ~clk;

  heap_feeder #(.DATA_WIDTH(8), .KEY_WIDTH(4), .NLEVELS(3)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_last     (s_last),
    .heap_din   (heap_din),
    .heap_en    (heap_en),
    .heap_init  (heap_init),
    .heap_flush (heap_flush),
    .heap_dout  (heap_dout),
    .heap_valid (heap_valid),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .busy       (busy),
    .done       (done),
`ifdef HEAP_FEEDER_DROPCNT_EN
    .drop_cnt   (drop_cnt),
`endif
    .err        (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a frame and push n items; gap inserts one idle cycle after that index.
  task automatic send_frame(input int n, input int gap);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("init_high", heap_init, 1);
    chk("busy_init", busy, 1);
    tick();
    chk("init_one_cycle", heap_init, 0);
    chk("fill_ready", s_ready, 1);
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_data  = items[i];
      s_last  = (i == n - 1);
      tick();
      if (i < 3 || i == n - 1) begin
        chk("en_lag", heap_en, 1);
        chk("din_match", heap_din, items[i]);
      end
      if (i == gap) begin
        s_valid = 1'b0;
        s_last  = 1'b0;
        tick();
        chk("en_idle", heap_en, 0);
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    chk("flush_high", heap_flush, 1);
    chk("ready_off_flush", s_ready, 0);
    tick();
    chk("flush_one_cycle", heap_flush, 0);
    chk("en_after_flush", heap_en, 0);
  endtask

  task automatic run_drain(input int nbeats, input int stall);
    out_n = 0;
    done_iter = -1;
    last_pop_iter = -1;
    for (int c = 0; c < 200; c++) begin
      heap_valid = (c < nbeats);
      heap_dout  = (c < nbeats) ? beats[c] : 8'h00;
      m_ready    = (c >= stall);
      if (stall > 0 && c > 0 && c < stall) chk("stall_hold", m_data, beats[0]);
      if (stall > 0 && c == stall) begin
        chk("full_no_err", err, 0);
        chk("full_valid", m_valid, 1);
      end
      if (m_valid && m_ready && out_n < 16) begin
        out_data[out_n] = m_data;
        out_last[out_n] = m_last;
        out_n++;
        last_pop_iter = c;
      end
      tick();
      if (done) begin
        done_iter = c;
        break;
      end
    end
    heap_valid = 1'b0;
    m_ready    = 1'b0;
    chk("drain_timeout", (done_iter >= 0), 1);
    chk("done_after_pop", done_iter, last_pop_iter);
    chk("idle_on_done", busy, 0);
    tick();
    chk("done_pulse", done, 0);
  endtask

  task automatic verify_out(input int n);
    chk("out_count", out_n, n);
    for (int i = 0; i < n && i < out_n; i++) begin
      chk("out_data", out_data[i], beats[i]);
      chk("out_last", out_last[i], (i == n - 1));
    end
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00;
    heap_valid = 1'b0; heap_dout = 8'h00; m_ready = 1'b0;

    // T1: reset, then reset again mid-FILL
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_mvalid", m_valid, 0);
    tick();
    rstn = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    s_valid = 1'b1;
    s_data  = 8'h3C;
    tick();
    chk("pre_rst_en", heap_en, 1);
    rstn = 1'b0;
    #1;
    chk("mid_rst_en", heap_en, 0);
    chk("mid_rst_din", heap_din, 0);
    chk("mid_rst_ready", s_ready, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_flush", heap_flush, 0);
    chk("mid_rst_mdata", m_data, 0);
    s_valid = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
    chk("post_rst_ready", s_ready, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_err", err, 0);

    // T2: keys 5,2,9 -> heap returns 9,5,2
    items[0] = 8'hA5; items[1] = 8'h32; items[2] = 8'h19;
    send_frame(3, 1);
    beats[0] = 8'h19; beats[1] = 8'hA5; beats[2] = 8'h32;
    run_drain(3, 0);
    verify_out(3);
    chk("t2_err", err, 0);
`ifdef HEAP_FEEDER_DROPCNT_EN
    chk("t2_drop", drop_cnt, 0);
`endif

    // T3: 20 items, only 7 come back
    for (int i = 0; i < 20; i++) items[i] = 8'((i * 37 + 11) % 256);
    send_frame(20, 25);
    beats[0] = 8'hFF; beats[1] = 8'hEE; beats[2] = 8'hDD; beats[3] = 8'hCC;
    beats[4] = 8'hBB; beats[5] = 8'hAA; beats[6] = 8'h99;
    run_drain(7, 0);
    verify_out(7);
    chk("t3_err", err, 0);
`ifdef HEAP_FEEDER_DROPCNT_EN
    chk("t3_drop", drop_cnt, 13);
`endif

    // T4: downstream stalled through the whole heap burst
    for (int i = 0; i < 7; i++) items[i] = 8'(8'h10 + i);
    send_frame(7, 25);
    beats[0] = 8'h16; beats[1] = 8'h15; beats[2] = 8'h14; beats[3] = 8'h13;
    beats[4] = 8'h12; beats[5] = 8'h11; beats[6] = 8'h10;
    run_drain(7, 12);
    verify_out(7);
    chk("t4_err", err, 0);

    // T5: stray heap beat in FILL and start while busy
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    heap_valid = 1'b1;
    heap_dout  = 8'h77;
    start      = 1'b1;
    tick();
    heap_valid = 1'b0;
    start      = 1'b0;
    chk("t5_err_set", err, 1);
    chk("t5_no_reinit", heap_init, 0);
    chk("t5_still_fill", s_ready, 1);
    tick();
    chk("t5_no_reinit2", heap_init, 0);
    s_valid = 1'b1;
    s_data  = 8'h44;
    s_last  = 1'b1;
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
    chk("t5_flush", heap_flush, 1);
    tick();
    beats[0] = 8'h44;
    run_drain(1, 0);
    verify_out(1);
    chk("t5_err_sticky", err, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t5_err_clear", err, 0);
    chk("t5_init", heap_init, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
